// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default widths for the I/D cache main-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int BLK_W_DEF  = 128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  function automatic grant_t other_grant(input grant_t g);
    return (g == GNT_I) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin selector: a tie goes to whichever requester was not granted last.
module arb_rr_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_t last_grant,
  output logic   grant_valid,
  output grant_t grant_sel
);

  always_comb begin
    grant_valid = req_i | req_d;
    grant_sel   = GNT_I;
    if (req_i && req_d) begin
      grant_sel = other_grant(last_grant);
    end else if (req_d) begin
      grant_sel = GNT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises I-cache reads and D-cache reads/writes onto one main-memory block port,
// with round-robin priority and per-requester combinational stall outputs.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BLK_W  = BLK_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic [BLK_W-1:0]  I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [BLK_W-1:0]  D_WRITEDATA,
  output logic [BLK_W-1:0]  D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [BLK_W-1:0]  MEM_WRITEDATA,
  input  logic [BLK_W-1:0]  MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  grant_t            r_last_grant;
  grant_t            w_grant_sel;
  logic              w_grant_valid;
  logic              w_req_i;
  logic              w_req_d;
  logic              w_mem_done;
  logic              r_seen_busy;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [BLK_W-1:0]  r_mem_wdata;
  logic [BLK_W-1:0]  r_i_readdata;
  logic [BLK_W-1:0]  r_d_readdata;

  assign w_req_i = I_READ;
  assign w_req_d = D_READ | D_WRITE;

  // Memory must have reported busy at least once before a low busywait counts as done.
  assign w_mem_done = r_seen_busy & ~MEM_BUSYWAIT;

  arb_rr_pick u_pick (
    .req_i       (w_req_i),
    .req_d       (w_req_d),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_sel   (w_grant_sel)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          if (w_grant_sel == GNT_I) w_state_next = BUSY_I;
          else                      w_state_next = BUSY_D;
        end
      end
      BUSY_I:  if (w_mem_done) w_state_next = RESP_I;
      BUSY_D:  if (w_mem_done) w_state_next = RESP_D;
      default: w_state_next = IDLE;
    endcase
  end

  // The operation is latched at grant so a withdrawn request still finishes its access.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= IDLE;
      r_last_grant <= GNT_I;
      r_seen_busy  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_i_readdata <= '0;
      r_d_readdata <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_last_grant <= w_grant_sel;
            r_seen_busy  <= 1'b0;
            if (w_grant_sel == GNT_I) begin
              r_mem_read  <= 1'b1;
              r_mem_write <= 1'b0;
              r_mem_addr  <= I_ADDR;
            end else begin
              r_mem_read  <= D_READ & ~D_WRITE;
              r_mem_write <= D_WRITE;
              r_mem_addr  <= D_ADDR;
              r_mem_wdata <= D_WRITEDATA;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (MEM_BUSYWAIT) r_seen_busy <= 1'b1;
          if (w_mem_done) begin
            r_seen_busy <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_state == BUSY_I)  r_i_readdata <= MEM_READDATA;
            else if (r_mem_read)    r_d_readdata <= MEM_READDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign I_BUSYWAIT    = w_req_i & (r_state != RESP_I);
  assign D_BUSYWAIT    = w_req_d & (r_state != RESP_D);
  assign I_READDATA    = r_i_readdata;
  assign D_READDATA    = r_d_readdata;
  assign MEM_READ      = r_mem_read;
  assign MEM_WRITE     = r_mem_write;
  assign MEM_ADDR      = r_mem_addr;
  assign MEM_WRITEDATA = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model, per-cycle
// compare process and hand-computed expectations for latency, ordering and reset.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int AW = 6;
  localparam int BW = 128;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          I_READ = 1'b0;
  logic [AW-1:0] I_ADDR = '0;
  logic [BW-1:0] I_READDATA;
  logic          I_BUSYWAIT;
  logic          D_READ = 1'b0;
  logic          D_WRITE = 1'b0;
  logic [AW-1:0] D_ADDR = '0;
  logic [BW-1:0] D_WRITEDATA = '0;
  logic [BW-1:0] D_READDATA;
  logic          D_BUSYWAIT;
  logic          MEM_READ;
  logic          MEM_WRITE;
  logic [AW-1:0] MEM_ADDR;
  logic [BW-1:0] MEM_WRITEDATA;
  logic [BW-1:0] MEM_READDATA;
  logic          MEM_BUSYWAIT;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(AW), .BLK_W(BW)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .I_READ        (I_READ),
    .I_ADDR        (I_ADDR),
    .I_READDATA    (I_READDATA),
    .I_BUSYWAIT    (I_BUSYWAIT),
    .D_READ        (D_READ),
    .D_WRITE       (D_WRITE),
    .D_ADDR        (D_ADDR),
    .D_WRITEDATA   (D_WRITEDATA),
    .D_READDATA    (D_READDATA),
    .D_BUSYWAIT    (D_BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDR      (MEM_ADDR),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Main memory: busy for mem_lat cycles from the first strobed cycle, then done.
  logic [BW-1:0] mem_arr [0:63];
  int mem_lat = 5;
  int mem_cnt = 0;
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt < mem_lat);
  assign MEM_READDATA = mem_arr[MEM_ADDR];
  always @(posedge CLK) begin
    if (MEM_WRITE && !MEM_BUSYWAIT) mem_arr[MEM_ADDR] <= MEM_WRITEDATA;
    if (!(MEM_READ | MEM_WRITE)) mem_cnt <= 0;
    else if (mem_cnt < mem_lat)  mem_cnt <= mem_cnt + 1;
  end

  // Reference model: owner 0=none 1=I 2=D; resp names who gets the one-cycle answer.
  int            m_owner = 0;
  int            m_resp  = 0;
  int            m_pref  = 2;
  int            m_k     = 0;
  bit            m_wr    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [BW-1:0] m_wdata = '0;
  logic [BW-1:0] m_ird   = '0;
  logic [BW-1:0] m_drd   = '0;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_owner = 0; m_resp = 0; m_pref = 2; m_k = 0; m_wr = 1'b0;
      m_addr = '0; m_wdata = '0; m_ird = '0; m_drd = '0;
    end else if (m_resp != 0) begin
      m_resp = 0;
    end else if (m_owner != 0) begin
      m_k++;
      if (m_k == mem_lat + 1) begin
        if (!m_wr) begin
          if (m_owner == 1) m_ird = mem_arr[m_addr];
          else              m_drd = mem_arr[m_addr];
        end
        m_resp  = m_owner;
        m_owner = 0;
      end
    end else if (I_READ || D_READ || D_WRITE) begin
      if (I_READ && (D_READ || D_WRITE)) m_owner = m_pref;
      else                               m_owner = I_READ ? 1 : 2;
      m_pref = 3 - m_owner;
      m_k    = 0;
      if (m_owner == 1) begin
        m_wr = 1'b0; m_addr = I_ADDR;
      end else begin
        m_wr = D_WRITE; m_addr = D_ADDR; m_wdata = D_WRITEDATA;
      end
    end
  end

  always @(negedge CLK) begin
    chk("i_busywait", BW'(I_BUSYWAIT), BW'(I_READ && m_resp != 1));
    chk("d_busywait", BW'(D_BUSYWAIT), BW'((D_READ || D_WRITE) && m_resp != 2));
    chk("mem_read",   BW'(MEM_READ),   BW'(m_owner != 0 && !m_wr));
    chk("mem_write",  BW'(MEM_WRITE),  BW'(m_owner != 0 && m_wr));
    chk("mem_addr",   BW'(MEM_ADDR),   BW'(m_addr));
    chk("mem_wdata",  MEM_WRITEDATA,   m_wdata);
    chk("i_readdata", I_READDATA,      m_ird);
    chk("d_readdata", D_READDATA,      m_drd);
  end

  // Grant log (address at each strobe rise) and length of the preceding strobe-low gap.
  logic [AW-1:0] glog [$];
  bit prev_strobe = 1'b0;
  int low_run = 0;
  int last_gap = -1;
  always @(negedge CLK) begin
    if ((MEM_READ | MEM_WRITE) && !prev_strobe) begin
      glog.push_back(MEM_ADDR);
      last_gap = low_run;
    end
    low_run     = (MEM_READ | MEM_WRITE) ? 0 : low_run + 1;
    prev_strobe = MEM_READ | MEM_WRITE;
  end

  task automatic do_i(input logic [AW-1:0] a, output int hi);
    bit ok = 1'b0;
    I_ADDR = a; I_READ = 1'b1; hi = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(posedge CLK);
      if (I_BUSYWAIT) hi++;
      else            ok = 1'b1;
    end
    #1 I_READ = 1'b0;
    chk("i_req_done", BW'(ok), BW'(1));
  endtask

  task automatic do_d(input bit rd, input bit wr, input logic [AW-1:0] a,
                      input logic [BW-1:0] wd, output int hi);
    bit ok = 1'b0;
    D_ADDR = a; D_WRITEDATA = wd; D_READ = rd; D_WRITE = wr; hi = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(posedge CLK);
      if (D_BUSYWAIT) hi++;
      else            ok = 1'b1;
    end
    #1;
    D_READ = 1'b0; D_WRITE = 1'b0;
    chk("d_req_done", BW'(ok), BW'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge CLK);
    #3 RESET = 1'b0;
    @(posedge CLK);
    #3 RESET = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int hi_i;
    int hi_d;
    bit seen;
    logic [BW-1:0] pat_a5;
    logic [BW-1:0] pat_10;
    pat_a5 = {16{8'hA5}};
    pat_10 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    for (int k = 0; k < 64; k++) mem_arr[k] = {4{32'hC0DE0000 + k}};
    mem_arr[6'h05] = pat_a5;
    mem_arr[6'h10] = pat_10;

    // Reset held with an I request pending
    I_ADDR = 6'h07; I_READ = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_mem_read",  BW'(MEM_READ),  BW'(0));
    chk("rst_mem_write", BW'(MEM_WRITE), BW'(0));
    chk("rst_mem_addr",  BW'(MEM_ADDR),  BW'(0));
    chk("rst_i_rdata",   I_READDATA,     '0);
    chk("rst_d_rdata",   D_READDATA,     '0);
    #2 RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("rel_mem_read", BW'(MEM_READ), BW'(1));
    chk("rel_mem_addr", BW'(MEM_ADDR), BW'(6'h07));
    do_i(6'h07, hi_i);
    idle(2);

    // Lone I read, latency 5: busywait high for 7 cycles
    do_i(6'h05, hi_i);
    chk("lone_i_bw_cycles", BW'(hi_i), BW'(7));
    chk("lone_i_rdata", I_READDATA, pat_a5);
    idle(2);

    // Lone D read then lone D write
    do_d(1'b1, 1'b0, 6'h10, '0, hi_d);
    chk("lone_d_rd_bw_cycles", BW'(hi_d), BW'(7));
    chk("lone_d_rdata", D_READDATA, pat_10);
    idle(1);
    do_d(1'b0, 1'b1, 6'h3F, 128'h1234, hi_d);
    chk("lone_d_wr_bw_cycles", BW'(hi_d), BW'(7));
    chk("d_wr_keeps_rdata", D_READDATA, pat_10);
    chk("d_wr_mem_content", mem_arr[6'h3F], 128'h1234);
    idle(1);

    // Tie right after reset: D first, then I
    pulse_reset();
    glog.delete();
    fork
      do_i(6'h05, hi_i);
      do_d(1'b1, 1'b0, 6'h10, '0, hi_d);
    join
    chk("tie1_count", BW'(glog.size()), BW'(2));
    if (glog.size() == 2) begin
      chk("tie1_first_d",  BW'(glog[0]), BW'(6'h10));
      chk("tie1_second_i", BW'(glog[1]), BW'(6'h05));
    end
    chk("tie1_d_bw", BW'(hi_d), BW'(7));
    chk("tie1_i_bw", BW'(hi_i), BW'(15));
    idle(1);

    // After a lone D grant, a repeat tie goes I then D
    do_d(1'b1, 1'b0, 6'h11, '0, hi_d);
    idle(1);
    glog.delete();
    fork
      do_i(6'h05, hi_i);
      do_d(1'b1, 1'b0, 6'h10, '0, hi_d);
    join
    chk("tie2_count", BW'(glog.size()), BW'(2));
    if (glog.size() == 2) begin
      chk("tie2_first_i",  BW'(glog[0]), BW'(6'h05));
      chk("tie2_second_d", BW'(glog[1]), BW'(6'h10));
    end
    chk("tie2_i_bw", BW'(hi_i), BW'(7));
    chk("tie2_d_bw", BW'(hi_d), BW'(15));
    idle(1);

    // Reset two cycles into a D write; held request regranted afterwards
    fork
      do_d(1'b0, 1'b1, 6'h20, 128'hDEAD_BEEF, hi_d);
      begin
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
          @(negedge CLK);
          if (MEM_WRITE) seen = 1'b1;
        end
        chk("midrst_grant_seen", BW'(seen), BW'(1));
        repeat (2) @(posedge CLK);
        #3 RESET = 1'b0;
        #1;
        chk("midrst_mem_write", BW'(MEM_WRITE), BW'(0));
        chk("midrst_mem_read",  BW'(MEM_READ),  BW'(0));
        chk("midrst_d_rdata",   D_READDATA,     '0);
        @(posedge CLK);
        #3 RESET = 1'b1;
      end
    join
    chk("midrst_regrant_wrote", mem_arr[6'h20], 128'hDEAD_BEEF);
    idle(2);

    // Back-to-back I reads: strobe low only for the RESP and IDLE cycles
    glog.delete();
    do_i(6'h05, hi_i);
    do_i(6'h07, hi_i);
    chk("b2b_count", BW'(glog.size()), BW'(2));
    chk("b2b_gap", BW'(last_gap), BW'(2));
    chk("b2b_second_bw", BW'(hi_i), BW'(7));
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
